// File: rtl/transpoe_bloco_stream.sv
`default_nettype none
// ============================================================================
// Module   : transpoe_bloco_stream
// Purpose  : Streaming transposition-cipher engine. Symbols enter one per
//            cycle and fill a ROWS x COLS matrix. They leave one per cycle in
//            transposed order. Two ping-pong banks give full throughput.
//            Short blocks (closed early by in_last) are padded with PAD.
// Ports    : clk, rst_n (synchronous, active-low)
//            mode      - 0 encrypt / 1 decrypt, captured on a block's first symbol
//            in_valid/in_ready/in_data/in_last     - symbol input stream
//            out_valid/out_ready/out_data/out_last - symbol output stream
// Revision : 1.0 - initial release
// ============================================================================
module transpoe_bloco_stream #(
    parameter int               ROWS  = 4,
    parameter int               COLS  = 4,
    parameter int               SYM_W = 8,
    parameter logic [SYM_W-1:0] PAD   = SYM_W'(8'h58)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_data,
    output logic             out_last
);

    localparam int c_N  = ROWS * COLS;
    localparam int c_IW = (c_N > 1) ? $clog2(c_N) : 1;
    localparam int c_CW = $clog2(c_N + 1);
    localparam int c_RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_KW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [1:0] c_EMPTY    = 2'd0;
    localparam logic [1:0] c_FILLING  = 2'd1;
    localparam logic [1:0] c_FULL     = 2'd2;
    localparam logic [1:0] c_DRAINING = 2'd3;

    // Per-bank bookkeeping
    logic [1:0]       r_state [2];
    logic             r_mode  [2];
    logic [c_CW-1:0]  r_count [2];
    logic [SYM_W-1:0] r_mem   [2][c_N];

    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [c_RW-1:0]  r_wr_row;
    logic [c_KW-1:0]  r_wr_col;
    logic [c_RW-1:0]  r_rd_row;
    logic [c_KW-1:0]  r_rd_col;
    logic [c_IW-1:0]  r_rd_pos;

    logic             w_wr_fire;
    logic             w_wr_mode;
    logic             w_wr_close;
    logic [c_IW-1:0]  w_wr_addr;
    logic [c_RW-1:0]  w_wr_row_nxt;
    logic [c_KW-1:0]  w_wr_col_nxt;
    logic             w_rd_load;
    logic             w_rd_last;
    logic [c_IW-1:0]  w_rd_phys;
    logic [c_CW-1:0]  w_rd_widx;
    logic [SYM_W-1:0] w_rd_sym;
    logic [c_RW-1:0]  w_rd_row_nxt;
    logic [c_KW-1:0]  w_rd_col_nxt;

    assign in_ready  = rst_n && ((r_state[r_wr_sel] == c_EMPTY) ||
                                 (r_state[r_wr_sel] == c_FILLING));
    assign w_wr_fire = in_valid && in_ready;

    // Storage is always physical row-major (r*COLS+c); only the walk order
    // of (r,c) changes. Encrypt writes with the column index moving fastest,
    // decrypt with the row index moving fastest; reads do the opposite.
    always_comb begin
        w_wr_mode    = (r_state[r_wr_sel] == c_EMPTY) ? mode : r_mode[r_wr_sel];
        w_wr_close   = (r_count[r_wr_sel] == c_CW'(c_N - 1)) || in_last;
        w_wr_addr    = c_IW'(int'(r_wr_row) * COLS + int'(r_wr_col));
        w_wr_row_nxt = r_wr_row;
        w_wr_col_nxt = r_wr_col;
        if (w_wr_mode) begin
            if (r_wr_row == c_RW'(ROWS - 1)) begin
                w_wr_row_nxt = '0;
                w_wr_col_nxt = r_wr_col + 1'b1;
            end else begin
                w_wr_row_nxt = r_wr_row + 1'b1;
            end
        end else begin
            if (r_wr_col == c_KW'(COLS - 1)) begin
                w_wr_col_nxt = '0;
                w_wr_row_nxt = r_wr_row + 1'b1;
            end else begin
                w_wr_col_nxt = r_wr_col + 1'b1;
            end
        end
    end

    // Read side: the write index of a physical cell tells whether it was
    // actually filled; anything at or beyond the fill count reads as PAD.
    always_comb begin
        w_rd_load    = ((r_state[r_rd_sel] == c_FULL) || (r_state[r_rd_sel] == c_DRAINING)) &&
                       (!out_valid || out_ready);
        w_rd_last    = (r_rd_pos == c_IW'(c_N - 1));
        w_rd_phys    = c_IW'(int'(r_rd_row) * COLS + int'(r_rd_col));
        w_rd_widx    = r_mode[r_rd_sel] ? c_CW'(int'(r_rd_col) * ROWS + int'(r_rd_row))
                                        : c_CW'(w_rd_phys);
        w_rd_sym     = (w_rd_widx < r_count[r_rd_sel]) ? r_mem[r_rd_sel][w_rd_phys] : PAD;
        w_rd_row_nxt = r_rd_row;
        w_rd_col_nxt = r_rd_col;
        if (!r_mode[r_rd_sel]) begin
            if (r_rd_row == c_RW'(ROWS - 1)) begin
                w_rd_row_nxt = '0;
                w_rd_col_nxt = r_rd_col + 1'b1;
            end else begin
                w_rd_row_nxt = r_rd_row + 1'b1;
            end
        end else begin
            if (r_rd_col == c_KW'(COLS - 1)) begin
                w_rd_col_nxt = '0;
                w_rd_row_nxt = r_rd_row + 1'b1;
            end else begin
                w_rd_col_nxt = r_rd_col + 1'b1;
            end
        end
    end

    // Write and read sides never touch the same bank in one cycle: the
    // writer only owns an EMPTY/FILLING bank, the reader only FULL/DRAINING.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= c_EMPTY;
                r_mode[b]  <= 1'b0;
                r_count[b] <= '0;
            end
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_wr_row  <= '0;
            r_wr_col  <= '0;
            r_rd_row  <= '0;
            r_rd_col  <= '0;
            r_rd_pos  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (w_wr_fire) begin
                if (r_state[r_wr_sel] == c_EMPTY) begin
                    r_mode[r_wr_sel] <= mode;
                end
                r_count[r_wr_sel] <= r_count[r_wr_sel] + 1'b1;
                if (w_wr_close) begin
                    r_state[r_wr_sel] <= c_FULL;
                    r_wr_sel          <= ~r_wr_sel;
                    r_wr_row          <= '0;
                    r_wr_col          <= '0;
                end else begin
                    r_state[r_wr_sel] <= c_FILLING;
                    r_wr_row          <= w_wr_row_nxt;
                    r_wr_col          <= w_wr_col_nxt;
                end
            end

            if (w_rd_load) begin
                out_valid <= 1'b1;
                out_data  <= w_rd_sym;
                out_last  <= w_rd_last;
                if (w_rd_last) begin
                    r_state[r_rd_sel] <= c_EMPTY;
                    r_count[r_rd_sel] <= '0;
                    r_rd_sel          <= ~r_rd_sel;
                    r_rd_row          <= '0;
                    r_rd_col          <= '0;
                    r_rd_pos          <= '0;
                end else begin
                    r_state[r_rd_sel] <= c_DRAINING;
                    r_rd_row          <= w_rd_row_nxt;
                    r_rd_col          <= w_rd_col_nxt;
                    r_rd_pos          <= r_rd_pos + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Symbol storage carries no reset; stale cells are masked by the fill count.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_sel][w_wr_addr] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_transpoe_bloco_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_transpoe_bloco_stream
// Purpose  : Scoreboard bench for transpoe_bloco_stream. Instance a is 4x4,
//            instance b is 2x3. Stimulus pushes expected blocks into a queue
//            and independent monitors pop and compare on every output transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_transpoe_bloco_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    logic       a_mode, a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last;
    logic [7:0] a_in_data, a_out_data;
    logic       b_mode, b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
    logic [7:0] b_in_data, b_out_data;

    transpoe_bloco_stream #(.ROWS(4), .COLS(4), .SYM_W(8), .PAD(8'h58)) u_a (
        .clk(clk), .rst_n(rst_n), .mode(a_mode),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last)
    );

    transpoe_bloco_stream #(.ROWS(2), .COLS(3), .SYM_W(8), .PAD(8'h58)) u_b (
        .clk(clk), .rst_n(rst_n), .mode(b_mode),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last)
    );

    int         tests = 0;
    int         fails = 0;
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic [8:0] ea, eb;
    int         s1, s2, s3, gaps;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_blk(input bit inst, input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (inst) qb.push_back({i == s.len() - 1, s[i]});
            else      qa.push_back({i == s.len() - 1, s[i]});
        end
    endtask

    // Sends s one symbol per accepted cycle; in_last on the final symbol
    // when close is set. mode flips after the first symbol to show it is ignored.
    task automatic send(input bit inst, input string s, input bit md, input bit close,
                        output int stalls);
        int n;
        stalls = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (inst) begin
                b_in_valid = 1'b1; b_in_data = s[i];
                b_in_last  = close && (i == s.len() - 1);
                b_mode     = (i == 0) ? md : ~md;
            end else begin
                a_in_valid = 1'b1; a_in_data = s[i];
                a_in_last  = close && (i == s.len() - 1);
                a_mode     = (i == 0) ? md : ~md;
            end
            n = 0;
            while (!(inst ? b_in_ready : a_in_ready) && n < 200) begin
                tick;
                n++;
            end
            stalls += n;
            if (n >= 200) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, expected accept", n);
            end
            tick;
        end
    endtask

    task automatic idle(input bit inst);
        if (inst) begin b_in_valid = 1'b0; b_in_last = 1'b0; end
        else      begin a_in_valid = 1'b0; a_in_last = 1'b0; end
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
            tick;
            n++;
        end
        repeat (3) tick;
        check("drain_queue_empty", qa.size() + qb.size(), 0);
    endtask

    task automatic watch_bubbles(input int len, output int g);
        int n;
        g = 0;
        n = 0;
        @(negedge clk);
        while (!a_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) g = 999;
        for (int i = 0; i < len; i++) begin
            if (!a_out_valid) g++;
            @(negedge clk);
        end
    endtask

    // Monitors: a transfer happens at the posedge following a negedge where
    // valid && ready is seen.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_unexpected: got %0h, expected no output", a_out_data);
            end else begin
                ea = qa.pop_front();
                check("a_data", a_out_data, ea[7:0]);
                check("a_last", a_out_last, ea[8]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected: got %0h, expected no output", b_out_data);
            end else begin
                eb = qb.pop_front();
                check("b_data", b_out_data, eb[7:0]);
                check("b_last", b_out_last, eb[8]);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_mode = 0; a_in_valid = 0; a_in_data = 0; a_in_last = 0; a_out_ready = 1;
        b_mode = 0; b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_out_ready = 1;
        repeat (3) tick;
        check("rst_a_in_ready", a_in_ready, 0);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_b_out_last", b_out_last, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_a_in_ready", a_in_ready, 1);
        check("post_rst_b_in_ready", b_in_ready, 1);

        // Encrypt then decrypt back to back on 4x4
        expect_blk(0, "PVECARSILATFATER");
        expect_blk(0, "PALAVRATESTECIFR");
        fork
            begin
                send(0, "PALAVRATESTECIFR", 1'b0, 1'b1, s1);
                send(0, "PVECARSILATFATER", 1'b1, 1'b1, s2);
                idle(0);
            end
            watch_bubbles(32, gaps);
        join
        check("b2b_in_stalls", s1 + s2, 0);
        check("b2b_out_bubbles", gaps, 0);
        drain;

        // 2x3 geometry
        expect_blk(1, "ADBECF");
        send(1, "ABCDEF", 1'b0, 1'b1, s1);
        expect_blk(1, "ABCDEF");
        send(1, "ADBECF", 1'b1, 1'b1, s2);
        idle(1);
        drain;

        // Short blocks: 13 symbols, then a single symbol
        expect_blk(0, "PVECARSXLATXATEX");
        send(0, "PALAVRATESTEC", 1'b0, 1'b1, s1);
        expect_blk(0, "ZXXXXXXXXXXXXXXX");
        send(0, "Z", 1'b0, 1'b1, s2);
        idle(0);
        drain;

        // Backpressure: three blocks against a stalled output
        a_out_ready = 1'b0;
        expect_blk(0, "PVECARSILATFATER");
        expect_blk(0, "PALAVRATESTECIFR");
        expect_blk(0, "AEIMBFJNCGKODHLP");
        fork
            begin
                send(0, "PALAVRATESTECIFR", 1'b0, 1'b1, s1);
                send(0, "PVECARSILATFATER", 1'b1, 1'b1, s2);
                send(0, "ABCDEFGHIJKLMNOP", 1'b0, 1'b1, s3);
                idle(0);
            end
        join_none
        repeat (40) tick;
        check("bp_in_ready_low", a_in_ready, 0);
        check("bp_out_valid_held", a_out_valid, 1);
        check("bp_out_data_held", a_out_data, 8'h50);
        check("bp_out_last_held", a_out_last, 0);
        a_out_ready = 1'b1;
        wait fork;
        drain;

        // Reset mid-block and mid-drain
        expect_blk(0, "PVECARSILATFATER");
        send(0, "PALAVRATESTECIFR", 1'b0, 1'b1, s1);
        send(0, "ABCDEFG", 1'b0, 1'b0, s2);
        idle(0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", a_in_ready, 0);
        tick;
        tick;
        qa.delete();
        rst_n = 1'b1;
        #1;
        check("after_rst_out_valid", a_out_valid, 0);
        check("after_rst_in_ready", a_in_ready, 1);
        expect_blk(0, "ABCDEFGHIJKLMNOP");
        send(0, "AEIMBFJNCGKODHLP", 1'b1, 1'b1, s1);
        idle(0);
        drain;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
